win_buf_2d: RTL and testbench

WIN_BUF_2D -- requirements
Module: win_buf_2d

---
 rtl/win_buf_2d_pkg.sv | 14 +
 rtl/axi4_stream_if.sv | 13 +
 rtl/win_buf_2d_line_ram.sv | 30 +++
 rtl/win_buf_2d.sv | 236 +++++++++++++++++++++++
 tb/tb_win_buf_2d.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/win_buf_2d_pkg.sv
// Shared types and helpers for the 2-D sliding-window buffer.
package win_buf_2d_pkg;

    typedef struct packed {
        logic tvalid;
        logic tlast;
        logic tuser;
    } win_ctrl_t;

    function automatic int win_tdata_width(input int px, input int w, input int h);
        return ((px * w * h + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle: tdata/tvalid/tready plus tlast and tuser.
interface axi4_stream_if #(
    parameter int TDATA_W = 8
);
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic               tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/win_buf_2d_line_ram.sv
// Simple dual-port line memory, registered read, old data returned on a same-address write.
module line_ram #(
    parameter int DEPTH = 1920,
    parameter int WIDTH = 10,
    parameter int AW    = 11
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/win_buf_2d.sv
// Sliding WIN_H x WIN_W window generator over an AXI4-Stream raster.
// Optional line-length checker enabled by defining WIN_BUF_2D_ERR_EN.
module win_buf_2d
    import win_buf_2d_pkg::*;
#(
    parameter int PX_WIDTH      = 10,
    parameter int WIN_W         = 3,
    parameter int WIN_H         = 3,
    parameter int MAX_LINE_SIZE = 1920,
    parameter int TDATA_WIDTH_I = 16,
    parameter int TDATA_WIDTH_O = 96
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master window_o
`ifdef WIN_BUF_2D_ERR_EN
    ,
    output logic          line_err_o
`endif
);

    localparam int CW     = (MAX_LINE_SIZE > 1) ? $clog2(MAX_LINE_SIZE) : 1;
    localparam int RW     = $clog2(WIN_H);
    localparam int NRAM   = WIN_H - 1;
    localparam int PACK_W = win_tdata_width(PX_WIDTH, WIN_W, WIN_H);
    localparam logic [CW-1:0] COL_LAST      = CW'(MAX_LINE_SIZE - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(WIN_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(WIN_H - 1);

    logic                     en;
    logic                     acc;
    logic [TDATA_WIDTH_I-1:0] vid_data;
    logic                     unused_vid;
    logic [PX_WIDTH-1:0]      px_p0;
    logic                     win_p0;
    logic                     sof_p0;

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic          frm_q, frm_d;
    logic          sof_pend_q, sof_pend_d;

    logic                vld_p1_q, win_p1_q, last_p1_q, sof_p1_q;
    logic [PX_WIDTH-1:0] px_p1_q;
    logic [CW-1:0]       col_p1_q;

    logic [PX_WIDTH-1:0] rd_data [NRAM];
    logic                wr_en   [NRAM];
    logic [CW-1:0]       wr_addr [NRAM];
    logic [PX_WIDTH-1:0] wr_data [NRAM];

    logic [PX_WIDTH-1:0] col_new [WIN_H];
    logic [PX_WIDTH-1:0] sr_q    [WIN_H][WIN_W];
    logic [PACK_W-1:0]   pack;
    win_ctrl_t           out_q, out_d;

    assign en             = !out_q.tvalid || window_o.tready;
    assign video_i.tready = en;
    assign acc            = video_i.tvalid && en;
    assign vid_data       = video_i.tdata;
    assign unused_vid     = ^vid_data;
    assign px_p0          = vid_data[PX_WIDTH-1:0];

    // Stage p0: raster position of the beat on the bus; a tuser beat is always (0,0).
    always_comb begin
        col_eff    = video_i.tuser ? '0 : col_q;
        row_eff    = video_i.tuser ? '0 : row_q;
        col_d      = col_q;
        row_d      = row_q;
        frm_d      = frm_q;
        sof_pend_d = sof_pend_q;
        win_p0     = acc && !video_i.tuser && frm_q &&
                     (row_q == ROW_LAST) && (col_q >= COL_FIRST_WIN);
        sof_p0     = win_p0 && sof_pend_q;
        if (acc) begin
            if (video_i.tuser) begin
                frm_d      = 1'b1;
                sof_pend_d = 1'b1;
            end
            if (win_p0) begin
                sof_pend_d = 1'b0;
            end
            if (video_i.tlast) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? row_eff : row_eff + 1'b1;
            end else begin
                col_d = (col_eff == COL_LAST) ? col_eff : col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    for (genvar k = 0; k < NRAM; k++) begin : g_ram
        if (k == 0) begin : g_head
            assign wr_en[k]   = acc;
            assign wr_addr[k] = col_eff;
            assign wr_data[k] = px_p0;
        end else begin : g_casc
            // Older lines move down one RAM a cycle later, once the upstream read has landed.
            assign wr_en[k]   = vld_p1_q && en;
            assign wr_addr[k] = col_p1_q;
            assign wr_data[k] = rd_data[k-1];
        end
        line_ram #(
            .DEPTH (MAX_LINE_SIZE),
            .WIDTH (PX_WIDTH),
            .AW    (CW)
        ) u_line_ram (
            .clk_i     (clk_i),
            .wr_en_i   (wr_en[k]),
            .wr_addr_i (wr_addr[k]),
            .wr_data_i (wr_data[k]),
            .rd_en_i   (acc),
            .rd_addr_i (col_eff),
            .rd_data_o (rd_data[k])
        );
    end

    // Stage p1: RAM reads are valid; assemble the incoming column, oldest line at y=0.
    always_comb begin
        for (int y = 0; y < WIN_H; y++) begin
            col_new[y] = (y == WIN_H - 1) ? px_p1_q : rd_data[WIN_H-2-y];
        end
    end

    always_comb begin
        out_d        = '0;
        out_d.tvalid = win_p1_q;
        out_d.tlast  = win_p1_q && last_p1_q;
        out_d.tuser  = win_p1_q && sof_p1_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q      <= '0;
            row_q      <= '0;
            frm_q      <= 1'b0;
            sof_pend_q <= 1'b0;
            vld_p1_q   <= 1'b0;
            win_p1_q   <= 1'b0;
            last_p1_q  <= 1'b0;
            sof_p1_q   <= 1'b0;
            out_q      <= '0;
            for (int y = 0; y < WIN_H; y++) begin
                for (int x = 0; x < WIN_W; x++) begin
                    sr_q[y][x] <= '0;
                end
            end
        end else if (en) begin
            col_q      <= col_d;
            row_q      <= row_d;
            frm_q      <= frm_d;
            sof_pend_q <= sof_pend_d;
            vld_p1_q   <= acc;
            win_p1_q   <= win_p0;
            last_p1_q  <= video_i.tlast;
            sof_p1_q   <= sof_p0;
            out_q      <= out_d;
            if (vld_p1_q) begin
                for (int y = 0; y < WIN_H; y++) begin
                    for (int x = 0; x < WIN_W - 1; x++) begin
                        sr_q[y][x] <= sr_q[y][x+1];
                    end
                    sr_q[y][WIN_W-1] <= col_new[y];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) begin
            px_p1_q  <= px_p0;
            col_p1_q <= col_eff;
        end
    end

    // Stage p2: the shift register is the window; pack it for the output beat.
    always_comb begin
        pack = '0;
        for (int y = 0; y < WIN_H; y++) begin
            for (int x = 0; x < WIN_W; x++) begin
                pack[(y*WIN_W+x)*PX_WIDTH +: PX_WIDTH] = sr_q[y][x];
            end
        end
    end

    assign window_o.tdata  = TDATA_WIDTH_O'(pack);
    assign window_o.tvalid = out_q.tvalid;
    assign window_o.tlast  = out_q.tlast;
    assign window_o.tuser  = out_q.tuser;

`ifdef WIN_BUF_2D_ERR_EN
    logic          err_q, err_d;
    logic          len_vld_q, len_vld_d;
    logic [CW-1:0] len_q, len_d;

    // len_q holds the column index of the first line's tlast pixel.
    always_comb begin
        err_d     = err_q;
        len_vld_d = len_vld_q;
        len_d     = len_q;
        if (acc) begin
            if (video_i.tuser) begin
                err_d     = 1'b0;
                len_vld_d = 1'b0;
            end
            if (video_i.tlast) begin
                if (!len_vld_d) begin
                    len_d     = col_eff;
                    len_vld_d = 1'b1;
                end else if (col_eff != len_q) begin
                    err_d = 1'b1;
                end
            end else if (col_eff == COL_LAST) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q     <= 1'b0;
            len_vld_q <= 1'b0;
            len_q     <= '0;
        end else begin
            err_q     <= err_d;
            len_vld_q <= len_vld_d;
            len_q     <= len_d;
        end
    end

    assign line_err_o = err_q;
`endif

endmodule

// File: tb/tb_win_buf_2d.sv
// Directed bench for win_buf_2d: 3x3 windows over 8x4 frames with stalls, aborts and reset.
module tb_win_buf_2d;

    localparam int PXW  = 10;
    localparam int WW   = 3;
    localparam int WH   = 3;
    localparam int TDI  = 16;
    localparam int TDO  = 96;

    logic clk;
    logic rst_n;
    logic line_err;

    axi4_stream_if #(.TDATA_W(TDI)) vid_if ();
    axi4_stream_if #(.TDATA_W(TDO)) win_if ();

    win_buf_2d #(
        .PX_WIDTH      (PXW),
        .WIN_W         (WW),
        .WIN_H         (WH),
        .MAX_LINE_SIZE (1920),
        .TDATA_WIDTH_I (TDI),
        .TDATA_WIDTH_O (TDO)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .video_i  (vid_if),
        .window_o (win_if)
`ifdef WIN_BUF_2D_ERR_EN
        ,
        .line_err_o (line_err)
`endif
    );

`ifndef WIN_BUF_2D_ERR_EN
    assign line_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int lat_start = 0;
    int rdy_bad = 0;
    bit rnd_rdy = 0;
    bit rdy_fixed = 1;

    logic [TDO-1:0] q_data[$];
    bit             q_user[$];
    bit             q_last[$];
    int             q_cyc[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [TDO-1:0] exp_win(input int base, input int r, input int c);
        logic [TDO-1:0] v;
        v = '0;
        for (int y = 0; y < WH; y++) begin
            for (int x = 0; x < WW; x++) begin
                v[(y*WW+x)*PXW +: PXW] = PXW'(base + (r - WH + 1 + y) * 16 + (c - WW + 1 + x));
            end
        end
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            win_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (win_if.tvalid && win_if.tready) begin
                q_data.push_back(win_if.tdata);
                q_user.push_back(win_if.tuser);
                q_last.push_back(win_if.tlast);
                q_cyc.push_back(cyc);
            end
            if (vid_if.tready !== (!win_if.tvalid || win_if.tready)) rdy_bad++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_q();
        q_data.delete();
        q_user.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic idle(input int n);
        vid_if.tvalid = 1'b0;
        vid_if.tuser  = 1'b0;
        vid_if.tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_px(input int px, input bit sof, input bit eol);
        int n;
        vid_if.tdata  = TDI'(px);
        vid_if.tuser  = sof;
        vid_if.tlast  = eol;
        vid_if.tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!vid_if.tready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 1000) begin
            tests++;
            fails++;
            $display("FAIL send_px timeout: observed tready=0 expected tready=1");
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int base, input int row, input int w,
                             input int c0, input int c1, input bit sof);
        for (int c = c0; c <= c1; c++) begin
            send_px(base + row * 16 + c, sof && (c == c0), c == w - 1);
        end
    endtask

    task automatic send_frame(input int base, input int w, input int h);
        for (int r = 0; r < h; r++) begin
            send_line(base, r, w, 0, w - 1, r == 0);
        end
    endtask

    task automatic check_frame(input int base, input int w, input int h, input int off);
        int k;
        k = off;
        for (int r = WH - 1; r < h; r++) begin
            for (int c = WW - 1; c < w; c++) begin
                if (k < q_data.size()) begin
                    chk("win_data", q_data[k], exp_win(base, r, c));
                    chk("win_user", q_user[k], k == off);
                    chk("win_last", q_last[k], c == w - 1);
                end else begin
                    chk("win_missing", q_data.size(), k + 1);
                end
                k++;
            end
        end
    endtask

    initial begin
        logic [TDO-1:0] first_win;
        first_win = {6'd0, 10'h022, 10'h021, 10'h020, 10'h012, 10'h011,
                     10'h010, 10'h002, 10'h001, 10'h000};

        rst_n         = 1'b0;
        vid_if.tvalid = 1'b0;
        vid_if.tuser  = 1'b0;
        vid_if.tlast  = 1'b0;
        vid_if.tdata  = '0;
        win_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", win_if.tvalid, 1'b0);
        chk("rst_tuser", win_if.tuser, 1'b0);
        chk("rst_tlast", win_if.tlast, 1'b0);
        chk("rst_tdata", win_if.tdata, '0);
        chk("rst_err", line_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 8x4 frame with latency measurement on the first window
        clear_q();
        send_line(0, 0, 8, 0, 7, 1);
        send_line(0, 1, 8, 0, 7, 0);
        send_line(0, 2, 8, 0, 1, 0);
        send_px(2 * 16 + 2, 1'b0, 1'b0);
        lat_start = acc_cyc;
        send_line(0, 2, 8, 3, 7, 0);
        send_line(0, 3, 8, 0, 7, 0);
        idle(10);
        chk("f1_count", q_data.size(), 12);
        chk("f1_first_data", q_data[0], first_win);
        chk("f1_latency", q_cyc[0] - lat_start, 2);
        check_frame(0, 8, 4, 0);

        // Same frame under random output back-pressure
        clear_q();
        rdy_bad = 0;
        rnd_rdy = 1;
        send_frame(0, 8, 4);
        idle(60);
        rnd_rdy = 0;
        idle(5);
        chk("bp_count", q_data.size(), 12);
        check_frame(0, 8, 4, 0);
        chk("bp_tready_rule", rdy_bad, 0);

        // Back-to-back frames; second must not carry first-frame pixels
        clear_q();
        send_frame(0, 8, 4);
        send_frame(8'h80, 8, 4);
        idle(10);
        chk("b2b_count", q_data.size(), 24);
        check_frame(0, 8, 4, 0);
        check_frame(8'h80, 8, 4, 12);

        // Frame aborted after two lines by a new tuser
        clear_q();
        send_line(8'h40, 0, 8, 0, 7, 1);
        send_line(8'h40, 1, 8, 0, 7, 0);
        send_frame(12'h100, 8, 4);
        idle(10);
        chk("abort_count", q_data.size(), 12);
        check_frame(12'h100, 8, 4, 0);

        // Lines shorter than the window produce nothing; a normal frame follows
        clear_q();
        send_frame(12'h200, 2, 4);
        idle(10);
        chk("short_count", q_data.size(), 0);
        send_frame(8'h10, 8, 4);
        idle(10);
        chk("short_next_count", q_data.size(), 12);
        check_frame(8'h10, 8, 4, 0);

        // Reset while a stalled window sits on the output, mid-line 2
        clear_q();
        rdy_fixed = 1'b0;
        idle(2);
        send_line(8'h20, 0, 8, 0, 7, 1);
        send_line(8'h20, 1, 8, 0, 7, 0);
        send_line(8'h20, 2, 8, 0, 3, 0);
        idle(3);
        chk("stall_tvalid", win_if.tvalid, 1'b1);
        chk("stall_tuser", win_if.tuser, 1'b1);
        chk("stall_data", win_if.tdata, exp_win(8'h20, 2, 2));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", win_if.tvalid, 1'b0);
        chk("arst_tuser", win_if.tuser, 1'b0);
        chk("arst_tlast", win_if.tlast, 1'b0);
        chk("arst_tdata", win_if.tdata, '0);
        @(negedge clk);
        rst_n     = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
        send_line(8'h20, 2, 8, 4, 7, 0);
        send_line(8'h20, 3, 8, 0, 7, 0);
        idle(10);
        chk("post_rst_no_win", q_data.size(), 0);
        send_frame(12'h300, 8, 4);
        idle(10);
        chk("post_rst_count", q_data.size(), 12);
        check_frame(12'h300, 8, 4, 0);

`ifdef WIN_BUF_2D_ERR_EN
        // Line lengths 8,8,7,8 flag an error until the next frame start
        clear_q();
        send_line(8'h50, 0, 8, 0, 7, 1);
        send_line(8'h50, 1, 8, 0, 7, 0);
        send_line(8'h50, 2, 7, 0, 5, 0);
        chk("err_before", line_err, 1'b0);
        send_px(8'h50 + 2 * 16 + 6, 1'b0, 1'b1);
        chk("err_rise", line_err, 1'b1);
        send_line(8'h50, 3, 8, 0, 7, 0);
        idle(4);
        chk("err_held", line_err, 1'b1);
        send_line(8'h60, 0, 8, 0, 0, 1);
        chk("err_clear", line_err, 1'b0);
        send_line(8'h60, 0, 8, 1, 7, 0);
        send_line(8'h60, 1, 8, 0, 7, 0);
        send_line(8'h60, 2, 8, 0, 7, 0);
        send_line(8'h60, 3, 8, 0, 7, 0);
        idle(10);
        chk("err_clean_frame", line_err, 1'b0);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
